// File: rtl/dma_h2c_byp_pkg.sv
// Shared types and helpers for the H2C descriptor-bypass-out sink and credit scheduler.
// QID_WIDTH may be overridden on the command line; it defaults to 11 bits.
`ifndef QID_WIDTH
`define QID_WIDTH 11
`endif

package dma_h2c_byp_pkg;

  localparam int unsigned CHN_W   = 2;
  localparam int unsigned MAX_CHN = 1 << CHN_W;
  localparam int unsigned DSC_W   = 128;
  localparam int unsigned QID_W   = `QID_WIDTH;
  localparam int unsigned CIDX_W  = 16;

  typedef struct packed {
    logic [DSC_W-1:0]  dsc;
    logic [QID_W-1:0]  qid;
    logic [CIDX_W-1:0] cidx;
    logic              wbi;
    logic              wbi_chk;
    logic              last;
    logic              lsiz;
  } byp_dsc_t;

  typedef struct packed {
    logic             found;
    logic [CHN_W-1:0] idx;
  } rr_pick_t;

  // First set bit of mask at or after ptr, wrapping; scanned far-to-near so the nearest wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_CHN-1:0] mask,
                                       input logic [CHN_W-1:0]   ptr);
    rr_pick_t         res;
    logic [CHN_W-1:0] idx;
    res = '0;
    for (int i = int'(MAX_CHN) - 1; i >= 0; i--) begin
      idx = ptr + CHN_W'(i);
      if (mask[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_h2c_byp_chn_fifo.sv
// Single-clock per-channel descriptor FIFO; the caller never pushes when full nor pops when empty.
module dma_h2c_byp_chn_fifo
  import dma_h2c_byp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  byp_dsc_t         din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output byp_dsc_t         head_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  byp_dsc_t         mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/dma_h2c_byp_out_crdt_sched.sv
// H2C bypass-out sink: per-channel FIFOs, round-robin credit return and round-robin output merge.
// Define DMA_H2C_BYP_CRDT_STATS_EN to add per-channel push/credit/drop counters.
module dma_h2c_byp_out_crdt_sched
  import dma_h2c_byp_pkg::*;
#(
  parameter int unsigned NUM_CHN    = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               axi_aclk,
  input  logic               axi_aresetn,
  input  logic               byp_vld,
  input  logic [CHN_W-1:0]   byp_chn,
  input  logic [DSC_W-1:0]   byp_dsc,
  input  logic [QID_W-1:0]   byp_qid,
  input  logic [CIDX_W-1:0]  byp_cidx,
  input  logic               byp_wbi,
  input  logic               byp_wbi_chk,
  input  logic               byp_last,
  input  logic               byp_lsiz,
  output logic               crdt,
  output logic [CHN_W-1:0]   crdt_chn,
  input  logic               crdt_en,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [CHN_W-1:0]   out_chn,
  output logic [DSC_W-1:0]   out_dsc,
  output logic [QID_W-1:0]   out_qid,
  output logic [CIDX_W-1:0]  out_cidx,
  output logic               out_wbi,
  output logic               out_wbi_chk,
  output logic               out_last,
  output logic               out_lsiz,
  output logic [NUM_CHN-1:0] ovf_err
`ifdef DMA_H2C_BYP_CRDT_STATS_EN
  ,
  output logic [NUM_CHN*32-1:0] stat_in_cnt,
  output logic [NUM_CHN*32-1:0] stat_crdt_cnt,
  output logic [NUM_CHN*32-1:0] stat_drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  byp_dsc_t                        din;
  byp_dsc_t                        head [NUM_CHN];
  logic [NUM_CHN-1:0]              hit, push, pop, full, empty, ovf_set, crdt_give;
  logic [NUM_CHN-1:0][CNT_W-1:0]   fifo_cnt;
  logic [NUM_CHN-1:0][CNT_W-1:0]   owed_q, owed_d;
  logic [MAX_CHN-1:0]              ne_mask, owed_mask;
  rr_pick_t                        out_pick, crdt_pick;
  logic [CHN_W-1:0]                out_ptr_q, out_ptr_d, crdt_ptr_q, crdt_ptr_d, sel_q, sel;
  logic [CHN_W-1:0]                crdt_chn_d;
  logic                            lock_q, crdt_d, chn_ok, hs;
  logic                            cnt_unused;

  function automatic logic [CHN_W-1:0] rr_next(input logic [CHN_W-1:0] idx);
    return (32'(idx) == NUM_CHN - 1) ? '0 : idx + CHN_W'(1);
  endfunction

  assign din = '{dsc: byp_dsc, qid: byp_qid, cidx: byp_cidx, wbi: byp_wbi,
                 wbi_chk: byp_wbi_chk, last: byp_last, lsiz: byp_lsiz};
  assign chn_ok = (32'(byp_chn) < NUM_CHN);

  for (genvar c = 0; c < NUM_CHN; c++) begin : g_chn
    dma_h2c_byp_chn_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk_i  (axi_aclk),
      .rst_ni (axi_aresetn),
      .push_i (push[c]),
      .din_i  (din),
      .pop_i  (pop[c]),
      .full_o (full[c]),
      .empty_o(empty[c]),
      .head_o (head[c]),
      .cnt_o  (fifo_cnt[c])
    );
  end

  // Occupancy is exported by the FIFO for debug taps; the scheduler only needs full/empty.
  assign cnt_unused = ^fifo_cnt;

  // Output arbiter: a stalled selection stays put until it handshakes.
  assign out_pick = rr_pick(ne_mask, out_ptr_q);
  assign sel      = lock_q ? sel_q : out_pick.idx;
  assign out_vld  = out_pick.found;
  assign hs       = out_vld && out_rdy;

  assign out_chn     = sel;
  assign out_dsc     = head[sel].dsc;
  assign out_qid     = head[sel].qid;
  assign out_cidx    = head[sel].cidx;
  assign out_wbi     = head[sel].wbi;
  assign out_wbi_chk = head[sel].wbi_chk;
  assign out_last    = head[sel].last;
  assign out_lsiz    = head[sel].lsiz;

  always_comb begin
    ne_mask    = '0;
    owed_mask  = '0;
    hit        = '0;
    push       = '0;
    pop        = '0;
    ovf_set    = '0;
    crdt_give  = '0;
    owed_d     = owed_q;
    crdt_d     = 1'b0;
    crdt_chn_d = crdt_chn;
    crdt_ptr_d = crdt_ptr_q;
    out_ptr_d  = out_ptr_q;
    for (int c = 0; c < NUM_CHN; c++) begin
      ne_mask[c]   = ~empty[c];
      owed_mask[c] = (owed_q[c] != '0);
      hit[c]       = byp_vld && chn_ok && (byp_chn == CHN_W'(c));
      push[c]      = hit[c] && !full[c];
      ovf_set[c]   = hit[c] && full[c];
      pop[c]       = hs && (sel == CHN_W'(c));
    end
    crdt_pick = rr_pick(owed_mask, crdt_ptr_q);
    if (crdt_en && crdt_pick.found) begin
      crdt_d     = 1'b1;
      crdt_chn_d = crdt_pick.idx;
      crdt_ptr_d = rr_next(crdt_pick.idx);
    end
    if (hs) out_ptr_d = rr_next(sel);
    // Credit decisions use this cycle's owed; a pop becomes creditable next cycle.
    for (int c = 0; c < NUM_CHN; c++) begin
      crdt_give[c] = crdt_d && (crdt_chn_d == CHN_W'(c));
      owed_d[c]    = owed_q[c] - CNT_W'(crdt_give[c]) + CNT_W'(pop[c]);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      owed_q     <= {NUM_CHN{DEPTH_C}};
      crdt       <= 1'b0;
      crdt_chn   <= '0;
      crdt_ptr_q <= '0;
      out_ptr_q  <= '0;
      sel_q      <= '0;
      lock_q     <= 1'b0;
      ovf_err    <= '0;
    end else begin
      owed_q     <= owed_d;
      crdt       <= crdt_d;
      crdt_chn   <= crdt_chn_d;
      crdt_ptr_q <= crdt_ptr_d;
      out_ptr_q  <= out_ptr_d;
      sel_q      <= sel;
      lock_q     <= out_vld && !out_rdy;
      ovf_err    <= ovf_err | ovf_set;
    end
  end

`ifdef DMA_H2C_BYP_CRDT_STATS_EN
  logic [NUM_CHN-1:0][31:0] in_cnt_q, crdt_cnt_q, drop_cnt_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      in_cnt_q   <= '0;
      crdt_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHN; c++) begin
        in_cnt_q[c]   <= in_cnt_q[c] + 32'(push[c]);
        crdt_cnt_q[c] <= crdt_cnt_q[c] + 32'(crdt_give[c]);
        drop_cnt_q[c] <= drop_cnt_q[c] + 32'(ovf_set[c]);
      end
    end
  end

  assign stat_in_cnt   = in_cnt_q;
  assign stat_crdt_cnt = crdt_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dma_h2c_byp_out_crdt_sched.sv
// Bench for dma_h2c_byp_out_crdt_sched: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed credit and output sequences.
`ifndef QID_WIDTH
`define QID_WIDTH 11
`endif

module tb_dma_h2c_byp_out_crdt_sched;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int QW = `QID_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          byp_vld = 1'b0;
  logic [1:0]    byp_chn = '0;
  logic [127:0]  byp_dsc = '0;
  logic [QW-1:0] byp_qid = '0;
  logic [15:0]   byp_cidx = '0;
  logic          byp_wbi = 1'b0, byp_wbi_chk = 1'b0, byp_last = 1'b0, byp_lsiz = 1'b0;
  logic          crdt_en = 1'b0, out_rdy = 1'b0;
  logic          crdt, out_vld;
  logic [1:0]    crdt_chn, out_chn;
  logic [127:0]  out_dsc;
  logic [QW-1:0] out_qid;
  logic [15:0]   out_cidx;
  logic          out_wbi, out_wbi_chk, out_last, out_lsiz;
  logic [N-1:0]  ovf_err;
`ifdef DMA_H2C_BYP_CRDT_STATS_EN
  logic [N*32-1:0] stat_in_cnt, stat_crdt_cnt, stat_drop_cnt;
`endif

  always #5 clk = ~clk;

  dma_h2c_byp_out_crdt_sched dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .byp_vld(byp_vld), .byp_chn(byp_chn), .byp_dsc(byp_dsc), .byp_qid(byp_qid),
    .byp_cidx(byp_cidx), .byp_wbi(byp_wbi), .byp_wbi_chk(byp_wbi_chk),
    .byp_last(byp_last), .byp_lsiz(byp_lsiz),
    .crdt(crdt), .crdt_chn(crdt_chn), .crdt_en(crdt_en),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_chn(out_chn), .out_dsc(out_dsc),
    .out_qid(out_qid), .out_cidx(out_cidx), .out_wbi(out_wbi), .out_wbi_chk(out_wbi_chk),
    .out_last(out_last), .out_lsiz(out_lsiz), .ovf_err(ovf_err)
`ifdef DMA_H2C_BYP_CRDT_STATS_EN
    , .stat_in_cnt(stat_in_cnt), .stat_crdt_cnt(stat_crdt_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, owed credits per channel, two round-robin pointers.
  logic [127:0] mq [N][$];
  int           m_owed [N];
  int           m_cptr = 0, m_optr = 0, m_lchn = 0;
  bit           m_lock = 1'b0, m_crdt = 1'b0;
  int           m_crdt_chn = 0;
  logic [N-1:0] m_ovf = '0;

  function automatic int m_sel();
    if (m_lock) return m_lchn;
    for (int i = 0; i < N; i++)
      if (mq[(m_optr + i) % N].size() > 0) return (m_optr + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        mq[c].delete();
        m_owed[c] = D;
      end
      m_cptr = 0; m_optr = 0; m_lock = 1'b0; m_lchn = 0;
      m_crdt = 1'b0; m_crdt_chn = 0; m_ovf = '0;
    end else begin
      automatic int s = m_sel();
      automatic bit p = (s >= 0) && out_rdy;
      m_crdt = 1'b0;
      if (crdt_en) begin
        for (int i = 0; i < N; i++) begin
          automatic int c = (m_cptr + i) % N;
          if (m_owed[c] > 0) begin
            m_crdt = 1'b1; m_crdt_chn = c; m_owed[c]--; m_cptr = (c + 1) % N;
            break;
          end
        end
      end
      if (byp_vld && int'(byp_chn) < N) begin
        if (mq[byp_chn].size() == D) m_ovf[byp_chn] = 1'b1;
        else mq[byp_chn].push_back(byp_dsc);
      end
      if (p) begin
        void'(mq[s].pop_front());
        m_owed[s]++;
        m_optr = (s + 1) % N;
      end
      m_lock = (s >= 0) && !out_rdy;
      m_lchn = s;
    end
  end

  int crdt_log[$];
  int pop_chn[$];
  int pop_tag[$];

  // Cycle compare against the model, plus logs for the directed checks.
  always @(negedge clk) begin
    automatic int s = m_sel();
    check("crdt", crdt, m_crdt);
    check("crdt_chn", crdt_chn, m_crdt_chn);
    check("ovf_err", ovf_err, m_ovf);
    check("out_vld", out_vld, s >= 0);
    if (s >= 0) begin
      check("out_chn", out_chn, s);
      check("out_dsc", out_dsc, mq[s][0]);
      check("out_cidx", out_cidx, mq[s][0][15:0]);
      check("out_qid", out_qid, QW'(s));
      check("out_side", {out_lsiz, out_last, out_wbi_chk, out_wbi}, mq[s][0][3:0]);
    end
    if (crdt) crdt_log.push_back(int'(crdt_chn));
    if (out_vld && out_rdy) begin
      pop_chn.push_back(int'(out_chn));
      pop_tag.push_back(int'(out_dsc[31:0]));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int chn, input int tag);
    byp_vld = 1'b1;
    byp_chn = 2'(chn);
    byp_dsc = 128'(tag);
    byp_cidx = 16'(tag);
    byp_qid = QW'(chn);
    {byp_lsiz, byp_last, byp_wbi_chk, byp_wbi} = 4'(tag);
    tick();
    byp_vld = 1'b0;
  endtask

  task automatic clear_logs();
    crdt_log.delete(); pop_chn.delete(); pop_tag.delete();
  endtask

  task automatic check_fresh_credits(input string nm);
    check({nm, "_n"}, crdt_log.size(), 32);
    for (int i = 0; i < crdt_log.size(); i++) check({nm, "_chn"}, crdt_log[i], i % 4);
    check({nm, "_idle"}, crdt, 1'b0);
  endtask

  initial begin
    crdt_en = 1'b1;
    tick(3);
    check("rst_crdt", crdt, 1'b0);
    check("rst_vld", out_vld, 1'b0);
    check("rst_ovf", ovf_err, '0);

    // Full pool drains round-robin after reset.
    clear_logs();
    rst_n = 1'b1;
    tick(40);
    check_fresh_credits("t1");

    // Credits held while chn 2 fills and drains.
    crdt_en = 1'b0;
    for (int i = 0; i < 8; i++) push(2, 'h200 + i);
    check("t2_vld", out_vld, 1'b1);
    check("t2_chn", out_chn, 2'd2);
    clear_logs();
    out_rdy = 1'b1;
    tick(10);
    out_rdy = 1'b0;
    check("t2_npop", pop_chn.size(), 8);
    for (int i = 0; i < pop_chn.size(); i++) begin
      check("t2_pchn", pop_chn[i], 2);
      check("t2_ptag", pop_tag[i], 'h200 + i);
    end
    check("t2_held", crdt_log.size(), 0);
    crdt_en = 1'b1;
    tick(10);
    check("t2_ncrdt", crdt_log.size(), 8);
    for (int i = 0; i < crdt_log.size(); i++) check("t2_cchn", crdt_log[i], 2);

    // Overflow on chn 1: ninth descriptor dropped, sticky flag.
    for (int i = 0; i < 8; i++) push(1, 'h100 + i);
    push(1, 'h1FF);
    check("t3_ovf", ovf_err, 4'b0010);
    clear_logs();
    out_rdy = 1'b1;
    tick(14);
    out_rdy = 1'b0;
    check("t3_npop", pop_chn.size(), 8);
    for (int i = 0; i < pop_tag.size(); i++) check("t3_ptag", pop_tag[i], 'h100 + i);
    check("t3_ovf_sticky", ovf_err, 4'b0010);
    check("t3_ncrdt", crdt_log.size(), 8);

    // chn 0 selected first and held under back-pressure even after chn 3 arrives.
    push(0, 'h300); push(0, 'h301); push(3, 'h330); push(3, 'h331);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_chn", out_chn, 2'd0);
      check("t4_hold_dsc", out_dsc, 128'h300);
      tick();
    end
    clear_logs();
    out_rdy = 1'b1;
    tick(6);
    out_rdy = 1'b0;
    check("t4_npop", pop_chn.size(), 4);
    for (int i = 0; i < pop_chn.size(); i++) check("t4_alt", pop_chn[i], (i % 2 == 0) ? 0 : 3);
    tick(8);

    // Pop and credit on chn 1 in the same cycle with owed=1.
    crdt_en = 1'b0;
    push(1, 'h140); push(1, 'h141);
    out_rdy = 1'b1;
    tick();
    clear_logs();
    crdt_en = 1'b1;
    tick();
    out_rdy = 1'b0;
    tick(4);
    check("t5_ncrdt", crdt_log.size(), 2);
    for (int i = 0; i < crdt_log.size(); i++) check("t5_cchn", crdt_log[i], 1);

    // Push and pop on chn 1 together keep occupancy at one.
    push(1, 'h150);
    out_rdy = 1'b1;
    push(1, 'h151);
    out_rdy = 1'b0;
    check("t5_pp_vld", out_vld, 1'b1);
    check("t5_pp_dsc", out_dsc, 128'h151);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("t5_pp_empty", out_vld, 1'b0);
    tick(6);

    // Reset in the middle of traffic.
    push(0, 'h400); push(0, 'h401); push(3, 'h430);
    out_rdy = 1'b1;
    tick(2);
    check("t6_pre_crdt", crdt, 1'b1);
    check("t6_pre_cchn", crdt_chn, 2'd0);
    check("t6_pre_vld", out_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_crdt", crdt, 1'b0);
    check("t6_rst_vld", out_vld, 1'b0);
    check("t6_rst_ovf", ovf_err, '0);
    out_rdy = 1'b0;
    tick(2);
    clear_logs();
    rst_n = 1'b1;
    tick(40);
    check_fresh_credits("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
